// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter shared types and constants.
// State codes, request sizes and the size decoder.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    MEMARB_IDLE  = 2'd0,
    MEMARB_READ  = 2'd1,
    MEMARB_WRITE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_LSQ = 1'b0,
    OWN_IF  = 1'b1
  } owner_t;

  localparam logic [2:0] SZ_B = 3'd1;
  localparam logic [2:0] SZ_H = 3'd2;
  localparam logic [2:0] SZ_W = 3'd4;

  localparam logic FALSE = 1'b0;
  localparam logic TRUE  = 1'b1;

  localparam logic [7:0] ZERO_BYTE = 8'h00;

  // Anything other than 1 or 2 bytes runs as a word.
  function automatic logic [2:0] size_bytes(input logic [2:0] sz);
    logic [2:0] n;
    case (sz)
      SZ_B:    n = SZ_B;
      SZ_H:    n = SZ_H;
      default: n = SZ_W;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter requester and RAM-pin bundle.
// slave = arbiter side, master = requesters/RAM side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              in_lsq_ena;
  logic              in_lsq_iswrite;
  logic [2:0]        in_lsq_size;
  logic [ADDR_W-1:0] in_lsq_addr;
  logic [DATA_W-1:0] in_lsq_wdata;
  logic              out_lsq_ready;
  logic [DATA_W-1:0] out_lsq_rdata;
  logic              in_if_ena;
  logic [ADDR_W-1:0] in_if_addr;
  logic              out_if_ready;
  logic [DATA_W-1:0] out_if_rdata;
  logic [7:0]        in_mem_din;
  logic [7:0]        out_mem_dout;
  logic [ADDR_W-1:0] out_mem_a;
  logic              out_mem_wr;

  modport slave (
    input  in_lsq_ena, in_lsq_iswrite,
    input  in_lsq_size, in_lsq_addr,
    input  in_lsq_wdata,
    output out_lsq_ready, out_lsq_rdata,
    input  in_if_ena, in_if_addr,
    output out_if_ready, out_if_rdata,
    input  in_mem_din,
    output out_mem_dout, out_mem_a,
    output out_mem_wr
  );

  modport master (
    output in_lsq_ena, in_lsq_iswrite,
    output in_lsq_size, in_lsq_addr,
    output in_lsq_wdata,
    input  out_lsq_ready, out_lsq_rdata,
    output in_if_ena, in_if_addr,
    input  out_if_ready, out_if_rdata,
    output in_mem_din,
    input  out_mem_dout, out_mem_a,
    input  out_mem_wr
  );
endinterface

// File: rtl/mem_arbiter_byte_engine.sv
// Serialises one granted access into RAM byte cycles.
// Reads are gathered little-endian into four lanes.
module mem_arbiter_byte_engine
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ena,
  input  logic              i_abort,
  input  logic              i_start,
  input  logic              i_iswrite,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [2:0]        i_size,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [7:0]        i_din,
  output logic [ADDR_W-1:0] o_mem_a,
  output logic [7:0]        o_mem_dout,
  output logic              o_mem_wr,
  output logic              o_idle,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rdata
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_cnt;
  logic [2:0]        r_n;
  logic [2:0]        w_n1;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_mem_a;
  logic [ADDR_W-1:0] w_a_nxt;
  logic [3:0][7:0]   r_wb;
  logic [3:0][7:0]   r_lanes;
  logic [3:0][7:0]   w_lanes;
  logic              r_pval;
  logic [1:0]        r_pidx;
  logic [7:0]        r_mem_dout;
  logic [7:0]        w_dout_nxt;
  logic              r_mem_wr;
  logic              w_wr_nxt;
  logic              w_is_wr;
  logic              w_is_rd;
  logic              w_issue;
  logic              w_abort;
  logic              w_done;
  logic              w_adv;

  assign w_n1    = r_cnt + 3'd1;
  assign w_is_wr = (r_state == MEMARB_WRITE);
  assign w_is_rd = (r_state == MEMARB_READ);
  assign w_issue = w_is_rd && (r_cnt < r_n);
  assign w_abort = i_abort && w_is_rd;
  assign w_done  = i_ena && !w_abort &&
                   ((w_is_wr && (w_n1 == r_n)) ||
                    (w_is_rd && (r_cnt == r_n)));
  assign w_adv   = i_ena && !o_idle &&
                   !w_done && !w_abort;

  // Lane view including the byte returning this cycle.
  always_comb begin
    w_lanes = r_lanes;
    if (r_pval) w_lanes[r_pidx] = i_din;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= MEMARB_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      MEMARB_IDLE:
        if (i_start)
          w_state_nxt = i_iswrite ? MEMARB_WRITE
                                  : MEMARB_READ;
      MEMARB_READ:
        if (w_done || w_abort)
          w_state_nxt = MEMARB_IDLE;
      MEMARB_WRITE:
        if (w_done) w_state_nxt = MEMARB_IDLE;
      default: w_state_nxt = MEMARB_IDLE;
    endcase
  end

  // Next RAM pin values; frozen cycles hold them.
  always_comb begin
    w_a_nxt    = r_mem_a;
    w_dout_nxt = r_mem_dout;
    w_wr_nxt   = r_mem_wr;
    unique case (1'b1)
      i_start: begin
        w_a_nxt    = i_addr;
        w_dout_nxt = i_iswrite ? i_wdata[7:0]
                               : ZERO_BYTE;
        w_wr_nxt   = i_iswrite;
      end
      (w_done || w_abort): begin
        w_a_nxt    = '0;
        w_dout_nxt = ZERO_BYTE;
        w_wr_nxt   = FALSE;
      end
      w_adv: begin
        if (w_n1 < r_n) begin
          w_a_nxt    = r_addr + ADDR_W'(w_n1);
          w_dout_nxt = w_is_wr ? r_wb[w_n1[1:0]]
                               : ZERO_BYTE;
          w_wr_nxt   = w_is_wr;
        end else begin
          w_a_nxt    = '0;
          w_dout_nxt = ZERO_BYTE;
          w_wr_nxt   = FALSE;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath: descriptor, counter, lanes and pins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_n        <= '0;
      r_addr     <= '0;
      r_wb       <= '0;
      r_lanes    <= '0;
      r_pval     <= FALSE;
      r_pidx     <= '0;
      r_mem_a    <= '0;
      r_mem_dout <= ZERO_BYTE;
      r_mem_wr   <= FALSE;
    end else begin
      r_mem_a    <= w_a_nxt;
      r_mem_dout <= w_dout_nxt;
      r_mem_wr   <= w_wr_nxt;
      r_pval     <= w_issue && !w_abort;
      r_pidx     <= r_cnt[1:0];
      if (i_start) begin
        r_cnt   <= '0;
        r_n     <= size_bytes(i_size);
        r_addr  <= i_addr;
        r_wb    <= i_wdata[31:0];
        r_lanes <= '0;
      end else begin
        r_lanes <= w_lanes;
        if (w_adv) r_cnt <= w_n1;
      end
    end
  end

  // A stalled write cycle must not strobe the RAM.
  assign o_mem_wr   = r_mem_wr && i_ena;
  assign o_mem_a    = r_mem_a;
  assign o_mem_dout = r_mem_dout;
  assign o_idle     = (r_state == MEMARB_IDLE);
  assign o_done     = w_done;
  assign o_rdata    = DATA_W'(w_lanes);

endmodule

// File: rtl/mem_arbiter.sv
// Byte-wide RAM port shared by LSQ and fetch.
// LSQ wins; reads are squashed on rollback.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         in_rollback,
  mem_arbiter_if.slave bus
);

  logic              r_lsq_v;
  logic              r_lsq_wr;
  logic [2:0]        r_lsq_size;
  logic [ADDR_W-1:0] r_lsq_addr;
  logic [DATA_W-1:0] r_lsq_wdata;
  logic              r_if_v;
  logic [ADDR_W-1:0] r_if_addr;
  owner_t            r_owner;
  logic              r_lsq_ready;
  logic [DATA_W-1:0] r_lsq_rdata;
  logic              r_if_ready;
  logic [DATA_W-1:0] r_if_rdata;

  logic              w_rb;
  logic              w_lsq_live;
  logic              w_if_live;
  logic              w_idle;
  logic              w_gnt_lsq;
  logic              w_gnt_if;
  logic              w_start;
  logic              w_lsq_take;
  logic              w_if_take;
  logic              w_done;
  logic              w_done_lsq;
  logic              w_done_if;
  logic [ADDR_W-1:0] w_addr;
  logic [2:0]        w_size;
  logic [DATA_W-1:0] w_wdata;
  logic              w_iswrite;
  logic [DATA_W-1:0] w_rdata;

  assign w_rb       = in_rollback && ena;
  assign w_lsq_live = r_lsq_v && !(w_rb && !r_lsq_wr);
  assign w_if_live  = r_if_v && !w_rb;
  assign w_gnt_lsq  = ena && w_idle && w_lsq_live;
  assign w_gnt_if   = ena && w_idle && w_if_live &&
                      !w_lsq_live;
  assign w_start    = w_gnt_lsq || w_gnt_if;
  assign w_lsq_take = bus.in_lsq_ena &&
                      !(w_rb && !bus.in_lsq_iswrite);
  assign w_if_take  = bus.in_if_ena && !w_rb;

  assign w_addr    = w_gnt_lsq ? r_lsq_addr : r_if_addr;
  assign w_size    = w_gnt_lsq ? r_lsq_size : SZ_W;
  assign w_wdata   = w_gnt_lsq ? r_lsq_wdata : '0;
  assign w_iswrite = w_gnt_lsq && r_lsq_wr;

  assign w_done_lsq = w_done && (r_owner == OWN_LSQ);
  assign w_done_if  = w_done && (r_owner == OWN_IF);

  mem_arbiter_byte_engine #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_eng (
    .clk        (clk),
    .rst        (rst),
    .i_ena      (ena),
    .i_abort    (w_rb),
    .i_start    (w_start),
    .i_iswrite  (w_iswrite),
    .i_addr     (w_addr),
    .i_size     (w_size),
    .i_wdata    (w_wdata),
    .i_din      (bus.in_mem_din),
    .o_mem_a    (bus.out_mem_a),
    .o_mem_dout (bus.out_mem_dout),
    .o_mem_wr   (bus.out_mem_wr),
    .o_idle     (w_idle),
    .o_done     (w_done),
    .o_rdata    (w_rdata)
  );

  // LSQ slot: new pulse, else grant or rollback clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lsq_v     <= FALSE;
      r_lsq_wr    <= FALSE;
      r_lsq_size  <= '0;
      r_lsq_addr  <= '0;
      r_lsq_wdata <= '0;
    end else if (w_lsq_take) begin
      r_lsq_v     <= TRUE;
      r_lsq_wr    <= bus.in_lsq_iswrite;
      r_lsq_size  <= bus.in_lsq_size;
      r_lsq_addr  <= bus.in_lsq_addr;
      r_lsq_wdata <= bus.in_lsq_wdata;
    end else if (w_gnt_lsq || !w_lsq_live) begin
      r_lsq_v     <= FALSE;
    end
  end

  // IF slot: new pulse, else grant or rollback clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_v    <= FALSE;
      r_if_addr <= '0;
    end else if (w_if_take) begin
      r_if_v    <= TRUE;
      r_if_addr <= bus.in_if_addr;
    end else if (w_gnt_if || w_rb) begin
      r_if_v    <= FALSE;
    end
  end

  // Owner tracking and one-cycle ready routing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner     <= OWN_LSQ;
      r_lsq_ready <= FALSE;
      r_lsq_rdata <= '0;
      r_if_ready  <= FALSE;
      r_if_rdata  <= '0;
    end else begin
      r_lsq_ready <= w_done_lsq;
      r_lsq_rdata <= w_done_lsq ? w_rdata : '0;
      r_if_ready  <= w_done_if;
      r_if_rdata  <= w_done_if ? w_rdata : '0;
      if (w_start)
        r_owner <= w_gnt_lsq ? OWN_LSQ : OWN_IF;
    end
  end

  assign bus.out_lsq_ready = r_lsq_ready;
  assign bus.out_lsq_rdata = r_lsq_rdata;
  assign bus.out_if_ready  = r_if_ready;
  assign bus.out_if_rdata  = r_if_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter.
// Cycle c0 is the cycle carrying the request pulse.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  logic ena;
  logic in_rollback;
  int   npass;
  int   ntot;
  int   nfail;

  logic [7:0] mem [0:65535];

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .in_rollback (in_rollback),
    .bus         (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous byte RAM; preloaded while reset is held.
  always @(posedge clk) begin
    if (!rst) begin
      mem[16'h0100] <= 8'h13;
      mem[16'h0101] <= 8'h05;
      mem[16'h0102] <= 8'h50;
      mem[16'h0103] <= 8'h00;
      mem[16'h2003] <= 8'h77;
      mem[16'hFFFF] <= 8'hAA;
      mem[16'h0000] <= 8'h55;
      bus.in_mem_din <= 8'h00;
    end else begin
      if (bus.out_mem_wr)
        mem[bus.out_mem_a[15:0]] <= bus.out_mem_dout;
      bus.in_mem_din <= mem[bus.out_mem_a[15:0]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    npass = 0;
    ntot  = 0;
    nfail = 0;
    rst = 1'b0;
    ena = 1'b1;
    in_rollback = 1'b0;
    bus.in_lsq_ena = 1'b0;
    bus.in_lsq_iswrite = 1'b0;
    bus.in_lsq_size = 3'd0;
    bus.in_lsq_addr = '0;
    bus.in_lsq_wdata = '0;
    bus.in_if_ena = 1'b0;
    bus.in_if_addr = '0;
    tick();
    tick();
    chk("rst_wr", bus.out_mem_wr, 0);
    chk("rst_a", bus.out_mem_a, 0);
    chk("rst_lsq_rdy", bus.out_lsq_ready, 0);
    chk("rst_if_rdy", bus.out_if_ready, 0);
    chk("rst_if_rd", bus.out_if_rdata, 0);
    rst = 1'b1;
    tick();

    // IF word read at 0x100
    bus.in_if_ena = 1'b1;
    bus.in_if_addr = 32'h100;
    tick();
    bus.in_if_ena = 1'b0;
    tick();
    chk("if_a_c2", bus.out_mem_a, 32'h100);
    chk("if_wr_c2", bus.out_mem_wr, 0);
    tick();
    chk("if_a_c3", bus.out_mem_a, 32'h101);
    tick();
    tick();
    chk("if_a_c5", bus.out_mem_a, 32'h103);
    tick();
    chk("if_rdy_c6", bus.out_if_ready, 0);
    chk("if_a_c6", bus.out_mem_a, 0);
    tick();
    chk("if_rdy_c7", bus.out_if_ready, 1);
    chk("if_rd_c7", bus.out_if_rdata, 32'h00500513);
    chk("if_lsqrdy_c7", bus.out_lsq_ready, 0);
    tick();
    chk("if_rdy_c8", bus.out_if_ready, 0);
    chk("if_rd_c8", bus.out_if_rdata, 0);

    // LSQ halfword store at 0x2001
    bus.in_lsq_ena = 1'b1;
    bus.in_lsq_iswrite = 1'b1;
    bus.in_lsq_size = 3'd2;
    bus.in_lsq_addr = 32'h2001;
    bus.in_lsq_wdata = 32'hDEADBEEF;
    tick();
    bus.in_lsq_ena = 1'b0;
    tick();
    chk("st_a_c2", bus.out_mem_a, 32'h2001);
    chk("st_d_c2", bus.out_mem_dout, 8'hEF);
    chk("st_wr_c2", bus.out_mem_wr, 1);
    tick();
    chk("st_a_c3", bus.out_mem_a, 32'h2002);
    chk("st_d_c3", bus.out_mem_dout, 8'hBE);
    chk("st_wr_c3", bus.out_mem_wr, 1);
    tick();
    chk("st_rdy_c4", bus.out_lsq_ready, 1);
    chk("st_rd_c4", bus.out_lsq_rdata, 0);
    chk("st_wr_c4", bus.out_mem_wr, 0);
    tick();
    chk("st_rdy_c5", bus.out_lsq_ready, 0);
    chk("st_m2001", mem[16'h2001], 8'hEF);
    chk("st_m2002", mem[16'h2002], 8'hBE);
    chk("st_m2003", mem[16'h2003], 8'h77);

    // LSQ byte load and IF fetch in the same cycle
    bus.in_lsq_ena = 1'b1;
    bus.in_lsq_iswrite = 1'b0;
    bus.in_lsq_size = 3'd1;
    bus.in_lsq_addr = 32'h2001;
    bus.in_if_ena = 1'b1;
    bus.in_if_addr = 32'h100;
    tick();
    bus.in_lsq_ena = 1'b0;
    bus.in_if_ena = 1'b0;
    tick();
    chk("pr_a_c2", bus.out_mem_a, 32'h2001);
    tick();
    tick();
    chk("pr_lrdy_c4", bus.out_lsq_ready, 1);
    chk("pr_lrd_c4", bus.out_lsq_rdata, 32'hEF);
    chk("pr_irdy_c4", bus.out_if_ready, 0);
    tick();
    chk("pr_a_c5", bus.out_mem_a, 32'h100);
    chk("pr_lrdy_c5", bus.out_lsq_ready, 0);
    repeat (4) tick();
    chk("pr_irdy_c9", bus.out_if_ready, 0);
    tick();
    chk("pr_irdy_c10", bus.out_if_ready, 1);
    chk("pr_ird_c10", bus.out_if_rdata, 32'h00500513);
    tick();
    chk("pr_irdy_c11", bus.out_if_ready, 0);
    chk("pr_lrdy_c11", bus.out_lsq_ready, 0);

    // rollback kills an active byte load and a queued fetch
    bus.in_lsq_ena = 1'b1;
    bus.in_lsq_iswrite = 1'b0;
    bus.in_lsq_size = 3'd1;
    bus.in_lsq_addr = 32'h100;
    tick();
    bus.in_lsq_ena = 1'b0;
    bus.in_if_ena = 1'b1;
    bus.in_if_addr = 32'h200;
    tick();
    bus.in_if_ena = 1'b0;
    chk("rb_a_c2", bus.out_mem_a, 32'h100);
    tick();
    in_rollback = 1'b1;
    tick();
    in_rollback = 1'b0;
    chk("rb_lrdy_c4", bus.out_lsq_ready, 0);
    chk("rb_a_c4", bus.out_mem_a, 0);
    tick();
    chk("rb_a_c5", bus.out_mem_a, 0);
    repeat (5) tick();
    chk("rb_irdy_c10", bus.out_if_ready, 0);
    chk("rb_lrdy_c10", bus.out_lsq_ready, 0);

    // store survives rollback, queued fetch dropped
    bus.in_lsq_ena = 1'b1;
    bus.in_lsq_iswrite = 1'b1;
    bus.in_lsq_size = 3'd4;
    bus.in_lsq_addr = 32'h3000;
    bus.in_lsq_wdata = 32'h11223344;
    tick();
    bus.in_lsq_ena = 1'b0;
    bus.in_if_ena = 1'b1;
    bus.in_if_addr = 32'h100;
    tick();
    bus.in_if_ena = 1'b0;
    chk("sr_a_c2", bus.out_mem_a, 32'h3000);
    chk("sr_d_c2", bus.out_mem_dout, 8'h44);
    tick();
    in_rollback = 1'b1;
    chk("sr_a_c3", bus.out_mem_a, 32'h3001);
    chk("sr_wr_c3", bus.out_mem_wr, 1);
    chk("sr_d_c3", bus.out_mem_dout, 8'h33);
    tick();
    in_rollback = 1'b0;
    tick();
    tick();
    chk("sr_rdy_c6", bus.out_lsq_ready, 1);
    tick();
    chk("sr_a_c7", bus.out_mem_a, 0);
    chk("sr_wr_c7", bus.out_mem_wr, 0);
    tick();
    chk("sr_word", {mem[16'h3003], mem[16'h3002],
                    mem[16'h3001], mem[16'h3000]},
        32'h11223344);
    repeat (4) tick();
    chk("sr_irdy_c12", bus.out_if_ready, 0);

    // 3-cycle stall in the middle of a word fetch
    bus.in_if_ena = 1'b1;
    bus.in_if_addr = 32'h100;
    tick();
    bus.in_if_ena = 1'b0;
    tick();
    chk("st3_a_c2", bus.out_mem_a, 32'h100);
    tick();
    tick();
    ena = 1'b0;
    chk("st3_a_c4", bus.out_mem_a, 32'h102);
    tick();
    chk("st3_a_c5", bus.out_mem_a, 32'h102);
    chk("st3_wr_c5", bus.out_mem_wr, 0);
    tick();
    chk("st3_a_c6", bus.out_mem_a, 32'h102);
    tick();
    ena = 1'b1;
    chk("st3_a_c7", bus.out_mem_a, 32'h102);
    chk("st3_rdy_c7", bus.out_if_ready, 0);
    tick();
    chk("st3_a_c8", bus.out_mem_a, 32'h103);
    tick();
    chk("st3_rdy_c9", bus.out_if_ready, 0);
    tick();
    chk("st3_rdy_c10", bus.out_if_ready, 1);
    chk("st3_rd_c10", bus.out_if_rdata, 32'h00500513);
    tick();

    // illegal size 3 behaves as a word load
    bus.in_lsq_ena = 1'b1;
    bus.in_lsq_iswrite = 1'b0;
    bus.in_lsq_size = 3'd3;
    bus.in_lsq_addr = 32'h100;
    tick();
    bus.in_lsq_ena = 1'b0;
    repeat (5) tick();
    chk("sz3_rdy_c6", bus.out_lsq_ready, 0);
    tick();
    chk("sz3_rdy_c7", bus.out_lsq_ready, 1);
    chk("sz3_rd_c7", bus.out_lsq_rdata, 32'h00500513);
    tick();

    // halfword load wrapping past the top of memory
    bus.in_lsq_ena = 1'b1;
    bus.in_lsq_size = 3'd2;
    bus.in_lsq_addr = 32'hFFFF_FFFF;
    tick();
    bus.in_lsq_ena = 1'b0;
    tick();
    chk("wr_a_c2", bus.out_mem_a, 32'hFFFF_FFFF);
    tick();
    chk("wr_a_c3", bus.out_mem_a, 32'h0);
    tick();
    tick();
    chk("wr_rdy_c5", bus.out_lsq_ready, 1);
    chk("wr_rd_c5", bus.out_lsq_rdata, 32'h55AA);
    tick();

    // fetch pulse latched while ena is low
    ena = 1'b0;
    bus.in_if_ena = 1'b1;
    bus.in_if_addr = 32'h100;
    tick();
    ena = 1'b1;
    bus.in_if_ena = 1'b0;
    tick();
    chk("el_a_c2", bus.out_mem_a, 32'h100);
    repeat (5) tick();
    chk("el_rdy_c7", bus.out_if_ready, 1);
    tick();

    // fetch pulse in a rollback cycle is dropped
    in_rollback = 1'b1;
    bus.in_if_ena = 1'b1;
    bus.in_if_addr = 32'h100;
    tick();
    in_rollback = 1'b0;
    bus.in_if_ena = 1'b0;
    tick();
    chk("rd_a_c2", bus.out_mem_a, 0);

    // store pulse in a rollback cycle, then async reset
    in_rollback = 1'b1;
    bus.in_lsq_ena = 1'b1;
    bus.in_lsq_iswrite = 1'b1;
    bus.in_lsq_size = 3'd4;
    bus.in_lsq_addr = 32'h4000;
    bus.in_lsq_wdata = 32'hCAFEF00D;
    tick();
    in_rollback = 1'b0;
    bus.in_lsq_ena = 1'b0;
    tick();
    chk("ar_a_c2", bus.out_mem_a, 32'h4000);
    chk("ar_wr_c2", bus.out_mem_wr, 1);
    tick();
    rst = 1'b0;
    #1;
    chk("ar_wr_now", bus.out_mem_wr, 0);
    chk("ar_a_now", bus.out_mem_a, 0);
    chk("ar_d_now", bus.out_mem_dout, 0);
    rst = 1'b1;
    tick();
    tick();
    chk("ar_a_after", bus.out_mem_a, 0);
    chk("ar_rdy_after", bus.out_lsq_ready, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single byte-wide RAM port between the load/store queue (data side) and instruction fetch.
- Serialises 1/2/4-byte accesses into byte cycles and reassembles read bytes little-endian.
- Returns a one-cycle ready pulse with the result to the winning requester.
- Sits between LSqueue/fetch and the top-level RAM pins; squashes speculative reads on rollback.

Parameters:
ADDR_W, 32, address width of requests and RAM address
DATA_W, 32, width of request write data and returned read data

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (rst=0 resets immediately)
ena  in  1  global ready/stall; low freezes the block
in_rollback  in  1  misbranch flush
in_lsq_ena  in  1  one-cycle request pulse from LSQ
in_lsq_iswrite  in  1  1=store, 0=load
in_lsq_size  in  3  byte count: 1, 2 or 4
in_lsq_addr  in  ADDR_W  byte address
in_lsq_wdata  in  DATA_W  store data, low bytes used
out_lsq_ready  out  1  completion pulse
out_lsq_rdata  out  DATA_W  load data, zero-extended (LSQ sign-extends)
in_if_ena  in  1  one-cycle fetch request pulse (always 4-byte read)
in_if_addr  in  ADDR_W  fetch address
out_if_ready  out  1  completion pulse
out_if_rdata  out  DATA_W  instruction word
in_mem_din  in  8  RAM read byte, valid one cycle after its address
out_mem_dout  out  8  RAM write byte
out_mem_a  out  ADDR_W  RAM byte address
out_mem_wr  out  1  1=write this cycle

Behaviour:
- Reset (rst=0, async): state IDLE, both pending slots empty, counter 0, all outputs 0.
- Pending slots:
  - Request pulses latch into an LSQ slot and an IF slot at any time, including while busy.
  - A second pulse into an occupied slot overwrites it. Requesters never issue one before their ready pulse.
- Grant (IDLE with ena):
  - Fixed priority: LSQ slot over IF slot.
  - The granted slot clears and its descriptor (addr, size, wdata, write flag, owner) is copied into the active registers.
- States: IDLE -> READ or WRITE -> IDLE. All outputs are registered.
- Start cycle: S = two cycles after the request pulse when IDLE with no competing requests.
- READ, N bytes:
  - out_mem_a = addr+k during cycle S+k, for k = 0..N-1, with out_mem_wr=0.
  - in_mem_din during S+k+1 is captured into byte lane k.
  - Ready pulse plus data in cycle S+N+1; the next grant can take effect in that same cycle.
  - Example, 4-byte read: pulse at c0, ready at c7.
- WRITE, N bytes:
  - out_mem_a = addr+k, out_mem_dout = wdata[8k+7:8k], out_mem_wr=1 during S+k.
  - out_lsq_ready pulses in cycle S+N; out_lsq_rdata = 0 for stores.
- Idle outputs: out_mem_a=0, out_mem_wr=0, out_mem_dout=0. Ready pulses last exactly one cycle; rdata is 0 when not ready.
- Address arithmetic wraps modulo 2^ADDR_W.
- Illegal size (not 1, 2 or 4) is treated as 4.
- ena low:
  - No state advances; out_mem_wr forced 0.
  - On ena high the byte currently addressed is re-issued. Bytes already captured are kept and no byte is written twice.
  - Request pulses are still latched while ena is low.
- Rollback (in_rollback=1 with ena):
  - IF slot cleared; the LSQ slot is cleared only if it holds a load.
  - An active read (IF or LSQ) aborts: next cycle is IDLE and no ready pulse is issued.
  - An active or pending store is never aborted and completes normally.
  - A request pulse arriving in the rollback cycle is dropped if it is a read and latched if it is a store.
- Reset mid-access aborts immediately; memory contents are undefined for a partially written word.

Decomposition:
- Shared constants go in constant.v: state encodings (MEMARB_IDLE/READ/WRITE), size codes (1/2/4), ZERO_DATA, FALSE/TRUE.
- One natural sub-module, mem_byte_engine: takes addr/size/wdata/iswrite/start and produces the byte stream, counter, lane assembly and done.
- The top level keeps the pending slots, priority, rollback and ready routing.

Test Plan:
- IF read 0x100, RAM bytes 0x13,0x05,0x50,0x00 -> out_if_ready exactly at c7 with out_if_rdata=0x00500513; out_mem_a runs 0x100..0x103 in c2..c5.
- LSQ store size 2, addr 0x2001, wdata 0xDEADBEEF -> bytes 0xEF to 0x2001 and 0xBE to 0x2002 with out_mem_wr=1 for two cycles; out_lsq_ready one cycle later.
- LSQ load and IF pulse in the same cycle -> LSQ served first; IF starts in the LSQ ready cycle; both ready pulses appear, each once.
- LSQ load size 1 active, rollback at its second cycle -> no out_lsq_ready, IDLE next cycle; a pending IF fetch is also cleared.
- Store active plus rollback -> store completes with ready pulse; a queued IF request is dropped.
- ena low for 3 cycles mid 4-byte read -> out_mem_wr stays 0 and the address holds; final word is correct with ready delayed by exactly 3 cycles. Async rst low mid-write -> all outputs 0 immediately.
